// File: rtl/dbus_responder_pkg.sv
// Shared types for the data-bus responder: request/response structs, access size, FSM states.
// Also provides the alignment helper used when DBUS_RESPONDER_ALIGN_CHECK_EN is defined.
package dbus_responder_pkg;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int unsigned CntW = 4;

  function automatic logic is_misaligned(msize_t size, logic [2:0] lo);
    logic mis;
    unique case (size)
      MSIZE1:  mis = 1'b0;
      MSIZE2:  mis = lo[0];
      MSIZE4:  mis = |lo[1:0];
      MSIZE8:  mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dbus_bram.sv
// Depth x 64-bit storage with combinational read and synchronous per-byte write.
// Contents have no reset.
module dbus_bram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [7:0]    we_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 8; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dbus_responder.sv
// Fixed-latency data-bus responder backed by a byte-writable word store.
// Define DBUS_RESPONDER_ALIGN_CHECK_EN to reject misaligned accesses with align_err.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       align_err
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     addr_q, addr_d;
  logic [63:0]     data_q, data_d;
  msize_t          size_q, size_d;
  logic [7:0]      strobe_q, strobe_d;
  logic            mis_q, mis_d;
  logic            addr_ok_q, addr_ok_d;
  logic            data_ok_q, data_ok_d;
  logic            align_q, align_d;
  logic            mis_now;
  logic [7:0]      we;
  logic [63:0]     rdata;

`ifdef DBUS_RESPONDER_ALIGN_CHECK_EN
  assign mis_now   = is_misaligned(dreq.size, dreq.addr[2:0]);
  assign align_err = align_q;
`else
  assign mis_now   = 1'b0;
  assign align_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    size_d    = size_q;
    strobe_d  = strobe_q;
    mis_d     = mis_q;
    addr_ok_d = 1'b0;
    data_ok_d = 1'b0;
    align_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dreq.valid) begin
          addr_d   = dreq.addr;
          data_d   = dreq.data;
          size_d   = dreq.size;
          strobe_d = dreq.strobe;
          mis_d    = mis_now;
          cnt_d    = CntLoad;
          if (LATENCY == 1) begin
            state_d   = StResp;
            addr_ok_d = 1'b1;
            data_ok_d = 1'b1;
            align_d   = mis_now;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (!dreq.valid) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          // Counter reaches 0 on this edge, so the response cycle starts now.
          if (cnt_q == CntW'(1)) begin
            state_d   = StResp;
            addr_ok_d = 1'b1;
            data_ok_d = 1'b1;
            align_d   = mis_q;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      size_q    <= MSIZE1;
      strobe_q  <= '0;
      mis_q     <= 1'b0;
      addr_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      align_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      size_q    <= size_d;
      strobe_q  <= strobe_d;
      mis_q     <= mis_d;
      addr_ok_q <= addr_ok_d;
      data_ok_q <= data_ok_d;
      align_q   <= align_d;
    end
  end

  // Write lands on the edge that leaves the response cycle; reset kills it via state_q.
  assign we = (state_q == StResp && !mis_q) ? strobe_q : 8'h00;

  dbus_bram #(
    .Depth(MEM_WORDS)
  ) u_bram (
    .clk_i  (clk),
    .addr_i (addr_q[AW+2:3]),
    .we_i   (we),
    .wdata_i(data_q),
    .rdata_o(rdata)
  );

  assign dresp.addr_ok = addr_ok_q;
  assign dresp.data_ok = data_ok_q;
  assign dresp.data    = (data_ok_q && !align_q) ? rdata : 64'h0;

  logic unused_sink;
  assign unused_sink = ^{addr_q[63:AW+3], addr_q[2:0], size_q, align_q};

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder (MEM_WORDS=1024, LATENCY=2); honours DBUS_RESPONDER_ALIGN_CHECK_EN.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       align_err;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] rd;
  logic        ae, ao;
  int          lat;
  int          seen;
  int          pulses[$];
  int          ao_mismatch;
  logic [63:0] b2b_data;

  always #5 clk = ~clk;

  dbus_responder #(
    .MEM_WORDS(1024),
    .LATENCY  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dreq     (dreq),
    .dresp    (dresp),
    .align_err(align_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from IDLE; waits at most 10 cycles for data_ok. scr perturbs fields after acceptance.
  task automatic access(input logic [63:0] a, input msize_t s, input logic [7:0] st,
                        input logic [63:0] d, input bit scr, output logic [63:0] rdo,
                        output logic aeo, output logic aoo, output int lato);
    @(posedge clk);
    #1;
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = s;
    dreq.strobe = st;
    dreq.data   = d;
    @(posedge clk);
    if (scr) begin
      #1;
      dreq.addr   = a ^ 64'h8;
      dreq.data   = ~d;
      dreq.strobe = 8'hFF;
    end
    lato = 0;
    rdo  = '0;
    aeo  = 1'b0;
    aoo  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (dresp.data_ok) begin
        lato = i;
        rdo  = dresp.data;
        aeo  = align_err;
        aoo  = dresp.addr_ok;
        break;
      end
    end
    @(posedge clk);
    #1;
    dreq = '0;
  endtask

  initial begin
    dreq  = '0;
    reset = 1'b1;
    #1;
    check("rst_addr_ok", 64'(dresp.addr_ok), 64'd0);
    check("rst_data_ok", 64'(dresp.data_ok), 64'd0);
    check("rst_data", dresp.data, 64'h0);
    check("rst_align", 64'(align_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    access(64'h10, MSIZE8, 8'hFF, 64'h1122334455667788, 1'b0, rd, ae, ao, lat);
    check("wr_full_lat", 64'(lat), 64'd2);
    check("wr_full_addr_ok", 64'(ao), 64'd1);
    access(64'h10, MSIZE8, 8'h00, 64'h0, 1'b0, rd, ae, ao, lat);
    check("rd_full_lat", 64'(lat), 64'd2);
    check("rd_full_data", rd, 64'h1122334455667788);
    check("rd_full_align", 64'(ae), 64'd0);

    access(64'h10, MSIZE8, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0, rd, ae, ao, lat);
    check("wr_part_old", rd, 64'h1122334455667788);
    access(64'h10, MSIZE8, 8'h00, 64'h0, 1'b0, rd, ae, ao, lat);
    check("rd_part_data", rd, 64'h11223344_BBBBBBBB);

    // Index uses addr[12:3]; everything above wraps.
    access(64'h2010, MSIZE8, 8'h00, 64'h0, 1'b0, rd, ae, ao, lat);
    check("rd_wrap_2010", rd, 64'h11223344_BBBBBBBB);
    access(64'hFFFF0000_00000010, MSIZE8, 8'h00, 64'h0, 1'b0, rd, ae, ao, lat);
    check("rd_wrap_high", rd, 64'h11223344_BBBBBBBB);

    access(64'h18, MSIZE8, 8'hFF, 64'h01234567_89ABCDEF, 1'b1, rd, ae, ao, lat);
    check("scr_lat", 64'(lat), 64'd2);
    access(64'h18, MSIZE8, 8'h00, 64'h0, 1'b0, rd, ae, ao, lat);
    check("scr_rd_18", rd, 64'h01234567_89ABCDEF);
    access(64'h10, MSIZE8, 8'h00, 64'h0, 1'b0, rd, ae, ao, lat);
    check("scr_rd_10", rd, 64'h11223344_BBBBBBBB);

    // Abort: valid drops in the cycle after acceptance.
    @(posedge clk);
    #1;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h10;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hDEADBEEF_CAFEF00D;
    @(posedge clk);
    #1;
    dreq = '0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dresp.data_ok) seen++;
    end
    check("abort_no_data_ok", 64'(seen), 64'd0);
    access(64'h10, MSIZE8, 8'h00, 64'h0, 1'b0, rd, ae, ao, lat);
    check("abort_rd", rd, 64'h11223344_BBBBBBBB);

    // Back-to-back reads with valid held high.
    ao_mismatch = 0;
    b2b_data    = '0;
    @(posedge clk);
    #1;
    dreq.valid = 1'b1;
    dreq.addr  = 64'h10;
    dreq.size  = MSIZE8;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dresp.addr_ok !== dresp.data_ok) ao_mismatch++;
      if (dresp.data_ok) begin
        pulses.push_back(i);
        b2b_data = dresp.data;
      end
    end
    @(posedge clk);
    #1;
    dreq = '0;
    check("b2b_count", 64'(pulses.size()), 64'd4);
    check("b2b_addr_ok_idle", 64'(ao_mismatch), 64'd0);
    check("b2b_data", b2b_data, 64'h11223344_BBBBBBBB);
    for (int k = 1; k < pulses.size(); k++) begin
      check("b2b_gap", 64'(pulses[k] - pulses[k-1]), 64'd3);
    end

    // Reset during BUSY of a write.
    @(posedge clk);
    #1;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h10;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'h55555555_55555555;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    dreq  = '0;
    #1;
    check("rst_busy_data_ok", 64'(dresp.data_ok), 64'd0);
    check("rst_busy_addr_ok", 64'(dresp.addr_ok), 64'd0);
    check("rst_busy_data", dresp.data, 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    access(64'h10, MSIZE8, 8'h00, 64'h0, 1'b0, rd, ae, ao, lat);
    check("rst_busy_rd", rd, 64'h11223344_BBBBBBBB);

    // Reset during the response cycle of a write also cancels the write.
    @(posedge clk);
    #1;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h10;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'h66666666_66666666;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_resp_pre", 64'(dresp.data_ok), 64'd1);
    reset = 1'b1;
    dreq  = '0;
    #1;
    check("rst_resp_data_ok", 64'(dresp.data_ok), 64'd0);
    check("rst_resp_data", dresp.data, 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    access(64'h10, MSIZE8, 8'h00, 64'h0, 1'b0, rd, ae, ao, lat);
    check("rst_resp_rd", rd, 64'h11223344_BBBBBBBB);

    // Misaligned 4-byte write to 0x12 (word 0x10, lanes 2..3).
    access(64'h12, MSIZE4, 8'h0C, 64'h00000000_99880000, 1'b0, rd, ae, ao, lat);
    check("mis_lat", 64'(lat), 64'd2);
`ifdef DBUS_RESPONDER_ALIGN_CHECK_EN
    check("mis_align_err", 64'(ae), 64'd1);
    check("mis_data", rd, 64'h0);
    access(64'h10, MSIZE8, 8'h00, 64'h0, 1'b0, rd, ae, ao, lat);
    check("mis_rd", rd, 64'h11223344_BBBBBBBB);
    access(64'h14, MSIZE4, 8'h00, 64'h0, 1'b0, rd, ae, ao, lat);
    check("al_align_err", 64'(ae), 64'd0);
    check("al_data", rd, 64'h11223344_BBBBBBBB);
`else
    check("mis_align_err", 64'(ae), 64'd0);
    check("mis_data", rd, 64'h11223344_BBBBBBBB);
    access(64'h10, MSIZE8, 8'h00, 64'h0, 1'b0, rd, ae, ao, lat);
    check("mis_rd", rd, 64'h11223344_9988BBBB);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
